// File: rtl/ram_wr_check_pkg.sv
// Shared types and the fill pattern for the block-RAM write/read-back checker.
`default_nettype none

package ram_wr_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // (addr + seed) mod 2^data_w; callers size-cast the result to their data width
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [31:0] seed,
                                          input int unsigned data_w);
    logic [31:0] mask;
    mask = (data_w >= 32) ? '1 : ((32'd1 << data_w) - 32'd1);
    return (addr + seed) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_checker.sv
// Read-back stage: delays the expected word and address by the RAM read latency,
// compares against ram_rdata_i and accumulates mismatch count / first bad address.
`default_nettype none

module ram_rd_checker
  import ram_wr_check_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              rd_vld_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [ADDR_W:0]   err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic              cmp_vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_dly_q;
  logic [ADDR_W:0]   err_cnt_q;
  logic [ADDR_W-1:0] first_err_q;
  logic              mism;

  assign mism = cmp_vld_q && (ram_rdata_i != exp_q);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      addr_dly_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      cmp_vld_q <= rd_vld_i;
      if (rd_vld_i) begin
        exp_q      <= exp_data_i;
        addr_dly_q <= rd_addr_i;
      end
      if (clr_i) begin
        err_cnt_q   <= '0;
        first_err_q <= '0;
      end else if (mism) begin
        err_cnt_q <= err_cnt_q + 1'b1;
        if (err_cnt_q == '0) first_err_q <= addr_dly_q;
      end
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

`default_nettype wire

// File: rtl/ram_wr_check.sv
// Block-RAM self test: fills every address with a seeded pattern, reads it back,
// and reports mismatch count, first failing address and pass/fail.
`default_nettype none

module ram_wr_check
  import ram_wr_check_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inj_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] seed_q;
  logic              inj_q;
  logic              pass_q;
  logic              accept;
  logic              rd_vld;
  logic [DATA_W-1:0] pat;

  assign pat = DATA_W'(pattern(32'(addr_q), 32'(seed_q), DATA_W));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    rd_vld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = ST_WRITE;
          accept  = 1'b1;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        rd_vld = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      inj_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (accept) begin
        inj_q  <= inj_err;
        pass_q <= 1'b0;
      end
      if (state_q == ST_DONE) begin
        pass_q <= (err_cnt == '0);
        seed_q <= seed_q + 1'b1;
      end
    end
  end

  ram_rd_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .clr_i            (accept),
    .rd_vld_i         (rd_vld),
    .rd_addr_i        (addr_q),
    .exp_data_i       (pat),
    .ram_rdata_i      (ram_rdata),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr)
  );

  // Injected fault flips bit 0 of the address-0 write only; the expected value stays clean
  assign ram_we    = (state_q == ST_WRITE);
  assign ram_addr  = addr_q;
  assign ram_wdata = (state_q == ST_WRITE)
                   ? (pat ^ DATA_W'(inj_q && (addr_q == '0)))
                   : '0;
  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_check.sv
// Directed bench for ram_wr_check with a behavioural 32x8 single-port RAM.
`default_nettype none

module tb_ram_wr_check;

  logic       sys_clk;
  logic       rst_n;
  logic       start;
  logic       inj_err;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_cnt;
  logic [4:0] first_err_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem    [32];
  logic [7:0] wr_log [32];
  int         n_writes = 0;
  logic       stuck = 1'b0;

  ram_wr_check #(.ADDR_W(5), .DATA_W(8)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .start          (start),
    .inj_err        (inj_err),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Single-port RAM, 1-cycle read latency; optional stuck-at-zero output
  always @(posedge sys_clk) begin
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      wr_log[ram_addr] <= ram_wdata;
      n_writes         <= n_writes + 1;
    end
    ram_rdata <= stuck ? 8'h00 : mem[ram_addr];
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // Returns number of edges from the accepting edge (counted as 1) to first done
  task automatic run_once(input logic inj, output int lat);
    @(negedge sys_clk);
    start   = 1'b1;
    inj_err = inj;
    @(posedge sys_clk);
    lat = 1;
    @(negedge sys_clk);
    start   = 1'b0;
    inj_err = 1'b0;
    while (!done && lat < 200) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if ({ram_we, ram_addr, ram_wdata, busy, done, pass, err_cnt, first_err_addr} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h busy=%b done=%b pass=%b cnt=%h first=%h, want all 0",
               ram_we, ram_addr, ram_wdata, busy, done, pass, err_cnt, first_err_addr);
    end
    w0 = n_writes;
    rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (n_writes != w0 || busy !== 1'b0 || ram_addr !== 5'd0) begin
      n_err++;
      $display("FAIL reset_idle: got writes=%0d busy=%b addr=%h, want writes=%0d busy=0 addr=0",
               n_writes - w0, busy, ram_addr, 0);
    end
  endtask

  task automatic test_first_run();
    int lat;
    run_once(1'b0, lat);
    n_vec++;
    if (lat != 66) begin
      n_err++;
      $display("FAIL run1_latency: got %0d, want 66", lat);
    end
    n_vec++;
    if (wr_log[5] !== 8'h05 || wr_log[31] !== 8'h1F) begin
      n_err++;
      $display("FAIL run1_wdata: got a5=%h a31=%h, want 05 1f", wr_log[5], wr_log[31]);
    end
    n_vec++;
    if (err_cnt !== 6'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL run1_done_state: got cnt=%0d busy=%b, want 0 0", err_cnt, busy);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (pass !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL run1_pass: got pass=%b done=%b, want 1 0", pass, done);
    end
  endtask

  task automatic test_second_run();
    int lat;
    run_once(1'b0, lat);
    n_vec++;
    if (lat != 66) begin
      n_err++;
      $display("FAIL run2_latency: got %0d, want 66", lat);
    end
    n_vec++;
    if (wr_log[31] !== 8'h20 || wr_log[0] !== 8'h01) begin
      n_err++;
      $display("FAIL run2_wdata: got a31=%h a0=%h, want 20 01", wr_log[31], wr_log[0]);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (pass !== 1'b1 || err_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL run2_pass: got pass=%b cnt=%0d, want 1 0", pass, err_cnt);
    end
  endtask

  task automatic test_inj_err();
    int lat;
    apply_reset();
    run_once(1'b1, lat);
    n_vec++;
    if (wr_log[0] !== 8'h01 || wr_log[1] !== 8'h01) begin
      n_err++;
      $display("FAIL inj_wdata: got a0=%h a1=%h, want 01 01", wr_log[0], wr_log[1]);
    end
    n_vec++;
    if (err_cnt !== 6'd1 || first_err_addr !== 5'd0) begin
      n_err++;
      $display("FAIL inj_count: got cnt=%0d first=%0d, want 1 0", err_cnt, first_err_addr);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (pass !== 1'b0) begin
      n_err++;
      $display("FAIL inj_pass: got %b, want 0", pass);
    end
  endtask

  task automatic test_stuck();
    int lat;
    apply_reset();
    stuck = 1'b1;
    run_once(1'b0, lat);
    n_vec++;
    if (err_cnt !== 6'd31 || first_err_addr !== 5'd1) begin
      n_err++;
      $display("FAIL stuck_count: got cnt=%0d first=%0d, want 31 1", err_cnt, first_err_addr);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    stuck = 1'b0;
    n_vec++;
    if (pass !== 1'b0 || err_cnt !== 6'd31) begin
      n_err++;
      $display("FAIL stuck_pass: got pass=%b cnt=%0d, want 0 31", pass, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int edges [3];
    int overlap;
    n_done  = 0;
    overlap = 0;
    apply_reset();
    @(negedge sys_clk);
    start = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (done) begin
        if (n_done < 3) edges[n_done] = e;
        n_done++;
      end
      if (done && busy) overlap++;
    end
    start = 1'b0;
    n_vec++;
    if (n_done != 3 || overlap != 0) begin
      n_err++;
      $display("FAIL b2b_count: got dones=%0d overlap=%0d, want 3 0", n_done, overlap);
    end else begin
      n_vec++;
      if (edges[0] != 66 || edges[1] != 133 || edges[2] != 200) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d %0d %0d, want 66 133 200", edges[0], edges[1], edges[2]);
      end
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b pass=%b, want 0 1", busy, pass);
    end
  endtask

  task automatic test_reset_mid_read();
    int n_done;
    int lat;
    n_done = 0;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (40) @(posedge sys_clk);
    @(negedge sys_clk);
    n_vec++;
    if (busy !== 1'b1 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL mid_in_read: got busy=%b we=%b, want 1 0", busy, ram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ram_we, ram_addr, ram_wdata, busy, done, pass, err_cnt, first_err_addr} !== 28'h0) begin
      n_err++;
      $display("FAIL mid_abort: got we=%b addr=%h busy=%b pass=%b cnt=%h first=%h, want all 0",
               ram_we, ram_addr, busy, pass, err_cnt, first_err_addr);
    end
    for (int e = 0; e < 80; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e == 3) rst_n = 1'b1;
      if (done) n_done++;
    end
    n_vec++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_done: got dones=%0d busy=%b, want 0 0", n_done, busy);
    end
    run_once(1'b0, lat);
    n_vec++;
    if (wr_log[31] !== 8'h1F || lat != 66) begin
      n_err++;
      $display("FAIL mid_seed_reset: got a31=%h lat=%0d, want 1f 66", wr_log[31], lat);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    inj_err = 1'b0;
    test_reset();
    test_first_run();
    test_second_run();
    test_inj_err();
    test_stuck();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_wr_check.md
# ram_wr_check

Writer/checker for a single-port block RAM (IP core, 1-cycle read latency, write-first irrelevant). On a start request it fills every RAM address with a deterministic pattern, reads every address back, compares against the expected pattern and reports an error count and pass/fail. It sits between the RAM IP instance and the debug logic analyser; the status outputs feed ILA probes or board LEDs.

## Interface
- ADDR_W, 5: RAM address width; DEPTH = 2^ADDR_W.
- DATA_W, 8: RAM data width.
- sys_clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled only in IDLE
- inj_err  in  1  error injection, sampled with accepted start
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
- busy  out  1  run in progress (WRITE, READ, DRAIN)
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last run had zero mismatches; held until next accepted start
- err_cnt  out  ADDR_W+1  mismatch count of current/last run
- first_err_addr  out  ADDR_W  address of first mismatch of current/last run

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: start=1 -> WRITE; addr<=0; err_cnt<=0; pass<=0; first_err_addr<=0; inj latch<=inj_err.
- WRITE: ram_we=1, ram_wdata = pattern(addr); addr+1 per cycle; at addr=DEPTH-1 -> READ, addr<=0.
- pattern(a) = (zero-extended a + seed) mod 2^DATA_W. With inj latch set, the write at address 0 has bit 0 inverted.
- READ: ram_we=0; addr+1 per cycle; exp_d<=pattern(addr), cmp_vld<=1; at addr=DEPTH-1 -> DRAIN.
- DRAIN: last compare only; -> DONE.
- Compare (cycle after each READ address): if cmp_vld and ram_rdata != exp_d: err_cnt+1; first_err_addr<=delayed addr if err_cnt was 0.
- DONE: done=1; pass<=(err_cnt==0); seed+1 (wraps mod 2^DATA_W); -> IDLE.
- start while busy or in DONE: ignored, not queued.
- Counter width ADDR_W+1 holds DEPTH mismatches; no saturation needed.

## Timing
- Reset: all outputs 0, state IDLE, seed 0, ram_addr 0.
- All outputs come from registers or registered-state decode; no input-to-output combinational path.
- start accepted at edge T: first WRITE cycle T+1, first READ cycle T+1+DEPTH, DRAIN at T+1+2*DEPTH, done high at T+2+2*DEPTH (T+66 for DEPTH=32).
- busy high from T+1 through DRAIN inclusive; low in DONE.
- ram_addr steps 0..DEPTH-1 consecutively in both phases, no bubbles; returns to 0 in IDLE.
- err_cnt and first_err_addr update 1 cycle after ram_rdata sampled; final in DONE cycle.
- rst_n low mid-run: immediate abort, all state/outputs to reset values, seed back to 0, no done pulse.

## Structure
- Package ram_wr_check_pkg: state enum, pattern function (addr, seed, DATA_W).
- Sub-module ram_rd_checker: exp_d/cmp_vld delay stage, comparator, err_cnt, first_err_addr capture; cleared by accepted start.
- Top holds FSM, address counter, seed, inj latch; RAM IP instantiated one level up.

## Test plan
- Reset with behavioural 32x8 RAM model: all outputs 0, state IDLE, no RAM writes.
- Single start pulse, seed 0: ram_wdata=0x05 at addr 5, 0x1F at addr 31; done at T+66; pass=1, err_cnt=0.
- Second run: seed 1, ram_wdata=0x20 at addr 31, 0x01 at addr 0; pass=1.
- inj_err=1 with start: addr 0 written 0x01 (seed 0); err_cnt=1, first_err_addr=0, pass=0.
- RAM model stuck output 0x00: err_cnt=31 (addr 0 matches), first_err_addr=1, pass=0.
- start held high 200 cycles: runs back-to-back, one done per 67 cycles, no restart while busy; rst_n low mid-READ clears all outputs with no done pulse.
